// File: rtl/hdmi_out_pkg.sv
// Shared constants and state encodings for the HDMI output frame-buffer read path.
package hdmi_out_pkg;

    localparam int unsigned BURST_WORDS_DEF = 64;
    localparam int unsigned FIFO_DEPTH_DEF  = 128;
    localparam logic [31:0] BYTES_PER_WORD  = 32'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_REQ,
        ST_WAIT_DONE,
        ST_NEXT_LINE
    } sched_state_t;

endpackage

// File: rtl/fb_addr_gen.sv
// Line/word position tracking for frame-buffer reads: current line address,
// word offset within the line, line count, and per-burst length clipped to the line end.
module fb_addr_gen
    import hdmi_out_pkg::*;
#(
    parameter int unsigned BURST_WORDS = BURST_WORDS_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic [31:0] i_base,
    input  logic [31:0] i_stride,
    input  logic [15:0] i_wpl,
    input  logic        i_adv,
    input  logic        i_next_line,
    output logic [31:0] o_addr,
    output logic [7:0]  o_len,
    output logic        o_line_end,
    output logic [11:0] o_line_cnt
);

    logic [31:0] r_line_addr;
    logic [31:0] r_stride;
    logic [15:0] r_wpl;
    logic [15:0] r_word_off;
    logic [11:0] r_line_cnt;
    logic [15:0] w_remain;

    always_comb begin
        w_remain   = r_wpl - r_word_off;
        o_line_end = (w_remain <= 16'(BURST_WORDS));
        o_len      = o_line_end ? w_remain[7:0] : 8'(BURST_WORDS);
        o_addr     = r_line_addr + ({16'd0, r_word_off} * BYTES_PER_WORD);
        o_line_cnt = r_line_cnt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_line_addr <= '0;
            r_stride    <= '0;
            r_wpl       <= '0;
            r_word_off  <= '0;
            r_line_cnt  <= '0;
        end else if (i_load) begin
            r_line_addr <= i_base;
            r_stride    <= i_stride;
            r_wpl       <= i_wpl;
            r_word_off  <= '0;
            r_line_cnt  <= '0;
        end else if (i_next_line) begin
            r_line_addr <= r_line_addr + r_stride;
            r_word_off  <= '0;
            r_line_cnt  <= r_line_cnt + 12'd1;
        end else if (i_adv) begin
            r_word_off  <= r_word_off + {8'd0, o_len};
        end
    end

endmodule

// File: rtl/fb_read_sched.sv
// Frame-buffer read scheduler: splits each frame into line-bounded bursts,
// throttled by FIFO space, with late-frame_start restart handling.
module fb_read_sched
    import hdmi_out_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = FIFO_DEPTH_DEF,
    parameter int unsigned BURST_WORDS = BURST_WORDS_DEF
) (
    input  logic        Bus2IP_Clk,
    input  logic        Bus2IP_Resetn,
    input  logic        enable,
    input  logic        frame_start,
    input  logic [31:0] frame_base_addr,
    input  logic [31:0] line_stride,
    input  logic [15:0] words_per_line,
    input  logic [11:0] lines_per_frame,
    input  logic [7:0]  fifo_count,
    output logic        rd_req,
    output logic [31:0] rd_addr,
    output logic [7:0]  rd_len,
    input  logic        rd_ack,
    input  logic        rd_done,
    output logic        busy,
    output logic        frame_done,
    output logic        late_err
);

    sched_state_t r_state;
    logic [11:0]  r_lpf;
    logic         r_restart_pend;
    logic [31:0]  r_pend_base;
    logic [31:0]  r_pend_stride;
    logic [15:0]  r_pend_wpl;
    logic [11:0]  r_pend_lpf;
    logic         r_rd_req;
    logic [31:0]  r_rd_addr;
    logic [7:0]   r_rd_len;
    logic         r_frame_done;
    logic         r_late_err;

    logic [31:0]  w_addr;
    logic [7:0]   w_len;
    logic         w_line_end;
    logic [11:0]  w_line_cnt;
    logic         w_start;
    logic         w_sel_pend;
    logic         w_pend_set;
    logic         w_cfg_zero;
    logic [31:0]  w_cfg_base;
    logic [31:0]  w_cfg_stride;
    logic [15:0]  w_cfg_wpl;
    logic [11:0]  w_cfg_lpf;
    logic [31:0]  w_space;
    logic         w_last_line;

    fb_addr_gen #(
        .BURST_WORDS (BURST_WORDS)
    ) u_addr_gen (
        .i_clk       (Bus2IP_Clk),
        .i_rst_n     (Bus2IP_Resetn),
        .i_load      (w_start && !w_cfg_zero),
        .i_base      (w_cfg_base),
        .i_stride    (w_cfg_stride),
        .i_wpl       (w_cfg_wpl),
        .i_adv       ((r_state == ST_WAIT_DONE) && rd_done),
        .i_next_line (r_state == ST_NEXT_LINE),
        .o_addr      (w_addr),
        .o_len       (w_len),
        .o_line_end  (w_line_end),
        .o_line_cnt  (w_line_cnt)
    );

    always_comb begin
        // A pending restart uses the config captured at the late frame_start,
        // unless a newer frame_start arrives together with rd_done.
        w_sel_pend   = (r_state == ST_WAIT_DONE) && rd_done && r_restart_pend && !frame_start;
        w_cfg_base   = w_sel_pend ? r_pend_base   : frame_base_addr;
        w_cfg_stride = w_sel_pend ? r_pend_stride : line_stride;
        w_cfg_wpl    = w_sel_pend ? r_pend_wpl    : words_per_line;
        w_cfg_lpf    = w_sel_pend ? r_pend_lpf    : lines_per_frame;
        w_cfg_zero   = (w_cfg_wpl == 16'd0) || (w_cfg_lpf == 12'd0);
        w_start      = 1'b0;
        case (r_state)
            ST_IDLE, ST_CHECK, ST_NEXT_LINE: w_start = frame_start && enable;
            ST_REQ:       w_start = frame_start && enable && !rd_ack;
            ST_WAIT_DONE: w_start = rd_done && ((frame_start && enable) || r_restart_pend);
            default:      w_start = 1'b0;
        endcase
        w_pend_set = frame_start && enable &&
                     (((r_state == ST_REQ) && rd_ack) || ((r_state == ST_WAIT_DONE) && !rd_done));
        w_space     = ({24'd0, fifo_count} >= FIFO_DEPTH) ? '0 : (FIFO_DEPTH - {24'd0, fifo_count});
        w_last_line = ((w_line_cnt + 12'd1) == r_lpf);
    end

    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            r_state        <= ST_IDLE;
            r_lpf          <= '0;
            r_restart_pend <= 1'b0;
            r_pend_base    <= '0;
            r_pend_stride  <= '0;
            r_pend_wpl     <= '0;
            r_pend_lpf     <= '0;
            r_rd_req       <= 1'b0;
            r_rd_addr      <= '0;
            r_rd_len       <= '0;
            r_frame_done   <= 1'b0;
            r_late_err     <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_late_err   <= 1'b0;
            case (r_state)
                ST_IDLE: ;
                ST_CHECK: begin
                    if (frame_start) r_late_err <= 1'b1;
                    if (!enable) begin
                        r_state <= ST_IDLE;
                    end else if (w_space >= {24'd0, w_len}) begin
                        r_state   <= ST_REQ;
                        r_rd_req  <= 1'b1;
                        r_rd_addr <= w_addr;
                        r_rd_len  <= w_len;
                    end
                end
                ST_REQ: begin
                    if (frame_start) r_late_err <= 1'b1;
                    if (rd_ack) begin
                        r_rd_req <= 1'b0;
                        r_state  <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (frame_start) r_late_err <= 1'b1;
                    if (rd_done) r_state <= w_line_end ? ST_NEXT_LINE : ST_CHECK;
                end
                ST_NEXT_LINE: begin
                    if (frame_start && !(enable && w_last_line)) r_late_err <= 1'b1;
                    if (!enable) begin
                        r_state <= ST_IDLE;
                    end else if (w_last_line) begin
                        r_frame_done <= 1'b1;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_state <= ST_CHECK;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_pend_set) begin
                r_restart_pend <= 1'b1;
                r_pend_base    <= frame_base_addr;
                r_pend_stride  <= line_stride;
                r_pend_wpl     <= words_per_line;
                r_pend_lpf     <= lines_per_frame;
            end
            // Frame (re)start overrides whatever the state case decided above.
            if (w_start) begin
                r_rd_req       <= 1'b0;
                r_restart_pend <= 1'b0;
                if (w_cfg_zero) begin
                    r_frame_done <= 1'b1;
                    r_state      <= ST_IDLE;
                end else begin
                    r_state <= ST_CHECK;
                    r_lpf   <= w_cfg_lpf;
                end
            end
        end
    end

    assign rd_req     = r_rd_req;
    assign rd_addr    = r_rd_addr;
    assign rd_len     = r_rd_len;
    assign busy       = (r_state != ST_IDLE);
    assign frame_done = r_frame_done;
    assign late_err   = r_late_err;

endmodule

// File: tb/tb_fb_read_sched.sv
// Directed self-checking bench for fb_read_sched with hand-computed burst sequences.
module tb_fb_read_sched;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        frame_start;
    logic [31:0] frame_base_addr;
    logic [31:0] line_stride;
    logic [15:0] words_per_line;
    logic [11:0] lines_per_frame;
    logic [7:0]  fifo_count;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic [7:0]  rd_len;
    logic        rd_ack;
    logic        rd_done;
    logic        busy;
    logic        frame_done;
    logic        late_err;

    int n_checks = 0;
    int n_errors = 0;
    int fd_cnt   = 0;
    int le_cnt   = 0;

    fb_read_sched #(
        .FIFO_DEPTH  (128),
        .BURST_WORDS (64)
    ) dut (
        .Bus2IP_Clk      (clk),
        .Bus2IP_Resetn   (rst_n),
        .enable          (enable),
        .frame_start     (frame_start),
        .frame_base_addr (frame_base_addr),
        .line_stride     (line_stride),
        .words_per_line  (words_per_line),
        .lines_per_frame (lines_per_frame),
        .fifo_count      (fifo_count),
        .rd_req          (rd_req),
        .rd_addr         (rd_addr),
        .rd_len          (rd_len),
        .rd_ack          (rd_ack),
        .rd_done         (rd_done),
        .busy            (busy),
        .frame_done      (frame_done),
        .late_err        (late_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_done) fd_cnt++;
        if (late_err)   le_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic start_frame(input logic [31:0] base, input logic [31:0] stride,
                               input logic [15:0] wpl, input logic [11:0] lpf);
        frame_base_addr = base;
        line_stride     = stride;
        words_per_line  = wpl;
        lines_per_frame = lpf;
        frame_start     = 1'b1;
        @(negedge clk);
        frame_start     = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int unsigned n = 0;
        while (!rd_req && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, {31'd0, rd_req}, 32'd1);
    endtask

    task automatic ack_req(input int unsigned dly, output int unsigned hi, output logic stable);
        logic [31:0] a0;
        logic [7:0]  l0;
        a0     = rd_addr;
        l0     = rd_len;
        hi     = 1;
        stable = 1'b1;
        for (int unsigned i = 0; i < dly; i++) begin
            rd_ack = 1'b0;
            @(negedge clk);
            if (rd_req) hi++;
            if (rd_addr !== a0 || rd_len !== l0) stable = 1'b0;
        end
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        check_eq("req_drop_after_ack", {31'd0, rd_req}, 32'd0);
    endtask

    task automatic pulse_done();
        rd_done = 1'b1;
        @(negedge clk);
        rd_done = 1'b0;
    endtask

    logic [31:0]  exp_a [6];
    logic [7:0]   exp_l [6];
    int unsigned  hi;
    int unsigned  hi_cnt;
    int unsigned  n;
    logic         stable;
    int           fd0;

    initial begin
        rst_n = 1'b0; enable = 1'b1; frame_start = 1'b0;
        frame_base_addr = '0; line_stride = '0; words_per_line = '0; lines_per_frame = '0;
        fifo_count = '0; rd_ack = 1'b0; rd_done = 1'b0;
        exp_a = '{32'h1000_0000, 32'h1000_0100, 32'h1000_0200, 32'h1000_1000, 32'h1000_1100, 32'h1000_1200};
        exp_l = '{8'd64, 8'd64, 8'd32, 8'd64, 8'd64, 8'd32};
        repeat (2) @(negedge clk);

        check_eq("rst_rd_req", {31'd0, rd_req}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check_eq("rst_late_err", {31'd0, late_err}, 32'd0);
        check_eq("rst_rd_addr", rd_addr, 32'd0);
        check_eq("rst_rd_len", {24'd0, rd_len}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Two lines of 160 words: 64+64+32 per line.
        fd0 = fd_cnt;
        start_frame(32'h1000_0000, 32'd4096, 16'd160, 12'd2);
        for (int i = 0; i < 6; i++) begin
            wait_req("basic_req_seen");
            check_eq($sformatf("basic_addr%0d", i), rd_addr, exp_a[i]);
            check_eq($sformatf("basic_len%0d", i), {24'd0, rd_len}, {24'd0, exp_l[i]});
            ack_req(0, hi, stable);
            if (i == 5) check_eq("basic_fd_early", fd_cnt - fd0, 32'd0);
            pulse_done();
        end
        repeat (3) @(negedge clk);
        check_eq("basic_fd_once", fd_cnt - fd0, 32'd1);
        check_eq("basic_idle", {31'd0, busy}, 32'd0);

        // FIFO throttling and delayed acceptance.
        fd0 = fd_cnt;
        fifo_count = 8'd100;
        start_frame(32'h2000_0000, 32'd4096, 16'd64, 12'd1);
        hi_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (rd_req) hi_cnt++;
        end
        check_eq("fifo_blocked", hi_cnt, 32'd0);
        check_eq("fifo_busy", {31'd0, busy}, 32'd1);
        fifo_count = 8'd64;
        n = 0;
        while (!rd_req && n < 2) begin
            @(negedge clk);
            n++;
        end
        check_eq("fifo_req_rise", {31'd0, rd_req}, 32'd1);
        check_eq("fifo_addr", rd_addr, 32'h2000_0000);
        ack_req(5, hi, stable);
        check_eq("ack_hold_stable", {31'd0, stable}, 32'd1);
        check_eq("ack_req_hi_cycles", hi, 32'd6);
        pulse_done();
        fifo_count = 8'd0;
        repeat (3) @(negedge clk);
        check_eq("fifo_fd", fd_cnt - fd0, 32'd1);

        // Late frame_start while waiting for rd_done.
        fd0 = fd_cnt;
        start_frame(32'h2000_0000, 32'd4096, 16'd160, 12'd2);
        wait_req("late_req_seen");
        check_eq("late_first_addr", rd_addr, 32'h2000_0000);
        ack_req(0, hi, stable);
        start_frame(32'h3000_0000, 32'd256, 16'd32, 12'd1);
        frame_base_addr = 32'h4444_0000;
        words_per_line  = 16'd16;
        hi_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (rd_req) hi_cnt++;
        end
        check_eq("late_err_once", le_cnt, 32'd1);
        check_eq("late_no_req_before_done", hi_cnt, 32'd0);
        pulse_done();
        wait_req("late_restart_req");
        check_eq("late_restart_addr", rd_addr, 32'h3000_0000);
        check_eq("late_restart_len", {24'd0, rd_len}, 32'd32);
        ack_req(0, hi, stable);
        pulse_done();
        repeat (3) @(negedge clk);
        check_eq("late_fd", fd_cnt - fd0, 32'd1);
        check_eq("late_err_total", le_cnt, 32'd1);

        // Address wrap-around across 2^32.
        start_frame(32'hFFFF_FF00, 32'd4096, 16'd128, 12'd1);
        wait_req("wrap_req0");
        check_eq("wrap_addr0", rd_addr, 32'hFFFF_FF00);
        ack_req(0, hi, stable);
        pulse_done();
        wait_req("wrap_req1");
        check_eq("wrap_addr1", rd_addr, 32'h0000_0000);
        check_eq("wrap_len1", {24'd0, rd_len}, 32'd64);
        ack_req(0, hi, stable);
        pulse_done();
        repeat (3) @(negedge clk);

        // Empty frame completes immediately.
        start_frame(32'h5000_0000, 32'd4096, 16'd0, 12'd4);
        check_eq("zero_fd_pulse", {31'd0, frame_done}, 32'd1);
        check_eq("zero_busy", {31'd0, busy}, 32'd0);
        check_eq("zero_no_req", {31'd0, rd_req}, 32'd0);

        // Asynchronous reset while requesting.
        start_frame(32'h6000_0000, 32'd4096, 16'd8, 12'd1);
        wait_req("rst_req_seen");
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_mid_rd_req", {31'd0, rd_req}, 32'd0);
        check_eq("rst_mid_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_mid_rd_addr", rd_addr, 32'd0);
        check_eq("rst_mid_rd_len", {24'd0, rd_len}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_after_idle", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
